cdb_arbiter: RTL

Result-broadcast stage downstream of the reservation stations: collects completed results from `ALU_RS_SIZE` functional-unit slots and drives them onto the `NUM_CDB_ENTRIES`-wide common data bus. It holds results in an age-ordered circular queue, so bursts larger than the bus width are never dropped. It applies per-source backpressure and drains oldest-first. Consumers are the reservation stations (tag wake-up) and the ROB (value write-back).

---
 rtl/cdb_arbiter_pkg.sv | 29 ++
 rtl/cdb_arbiter_if.sv | 39 +++
 rtl/cdb_arbiter_mp_result_queue.sv | 105 ++++++++++
 rtl/cdb_arbiter.sv | 80 ++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_arbiter_pkg
//  Purpose  : Shared sizes and bus types for the CDB broadcast stage.
//  Revision : 1.0  initial release
// ============================================================================
package cdb_arbiter_pkg;

  // Machine-wide sizing
  localparam int ALU_RS_SIZE     = 4;
  localparam int NUM_CDB_ENTRIES = 2;
  localparam int CDB_QUEUE_DEPTH = 8;

  // Payload widths
  localparam int TAG_W  = 8;
  localparam int DATA_W = 32;

  // One broadcast/producer slot: valid qualifies tag and value
  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] value;
  } cdb_entry_t;

  // Whole common data bus, lane 0 is always the oldest result
  typedef cdb_entry_t [NUM_CDB_ENTRIES-1:0] cdb_t;

endpackage
`default_nettype wire

// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_arbiter_if
//  Purpose  : Producer handshake, flush and broadcast lanes of the CDB stage.
//             master = reservation-station side, slave = the arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int N_SRC = ALU_RS_SIZE,
  parameter int N_CDB = NUM_CDB_ENTRIES,
  parameter int DEPTH = CDB_QUEUE_DEPTH
) ();

  logic                         flush;
  cdb_entry_t [N_SRC-1:0]       src_i;
  logic [N_SRC-1:0]             src_ready_o;
  cdb_entry_t [N_CDB-1:0]       cdb_o;
  logic [$clog2(DEPTH+1)-1:0]   count_o;

  modport master (
    output flush,
    output src_i,
    input  src_ready_o,
    input  cdb_o,
    input  count_o
  );

  modport slave (
    input  flush,
    input  src_i,
    output src_ready_o,
    output cdb_o,
    output count_o
  );

endinterface
`default_nettype wire

// File: rtl/cdb_arbiter_mp_result_queue.sv
`default_nettype none
// ============================================================================
//  Module   : mp_result_queue
//  Purpose  : Multi-push / multi-pop circular buffer. Sparse push requests are
//             packed into consecutive slots from tail in ascending port order;
//             the head window of N_POP entries is exposed combinationally.
//  Revision : 1.0  initial release
// ============================================================================
module mp_result_queue #(
  parameter int N_PUSH = 4,
  parameter int N_POP  = 2,
  parameter int DEPTH  = 8,
  parameter int W      = 40,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH+1)
) (
  input  logic                        clk,
  input  logic                        rst,          // async, active-low
  input  logic                        i_flush,
  input  logic [N_PUSH-1:0]           i_push_vld,
  input  logic [N_PUSH-1:0][W-1:0]    i_push_data,
  input  logic [CW-1:0]               i_pop_n,      // caller keeps this <= count
  output logic [N_POP-1:0][W-1:0]     o_rd_data,
  output logic [N_POP-1:0]            o_rd_vld,
  output logic [CW-1:0]               o_count
);

  logic [W-1:0]               r_mem [DEPTH];
  logic [DEPTH-1:0]           r_vld;
  logic [PW-1:0]              r_head;
  logic [PW-1:0]              r_tail;
  logic [CW-1:0]              r_count;

  logic [N_PUSH-1:0][PW-1:0]  w_wr_idx;
  logic [CW-1:0]              w_push_n;
  logic [DEPTH-1:0]           w_vld_set;
  logic [DEPTH-1:0]           w_vld_clr;

  // Pack accepted pushes: each one lands after all lower-indexed accepted pushes
  always_comb begin
    w_push_n  = '0;
    w_vld_set = '0;
    for (int i = 0; i < N_PUSH; i++) begin
      w_wr_idx[i] = r_tail + w_push_n[PW-1:0];
      if (i_push_vld[i]) begin
        w_vld_set[w_wr_idx[i]] = 1'b1;
        w_push_n               = w_push_n + CW'(1);
      end
    end
  end

  // Slots retired this cycle; they never overlap the push slots because
  // producers are only admitted into slots that were free before the pop
  always_comb begin
    w_vld_clr = '0;
    for (int k = 0; k < N_POP; k++) begin
      if (CW'(k) < i_pop_n) begin
        w_vld_clr[r_head + PW'(k)] = 1'b1;
      end
    end
  end

  // Head window read-out, straight from storage
  always_comb begin
    for (int k = 0; k < N_POP; k++) begin
      o_rd_data[k] = r_mem[r_head + PW'(k)];
      o_rd_vld[k]  = r_vld[r_head + PW'(k)];
    end
  end

  // Pointer, occupancy and slot-valid state; flush empties the queue and drops pushes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      r_head  <= r_head + i_pop_n[PW-1:0];
      r_tail  <= r_tail + w_push_n[PW-1:0];
      r_count <= r_count + w_push_n - i_pop_n;
      r_vld   <= (r_vld & ~w_vld_clr) | w_vld_set;
    end
  end

  // Payload storage; contents are qualified by r_vld so it needs no reset
  always_ff @(posedge clk) begin
    if (!i_flush) begin
      for (int i = 0; i < N_PUSH; i++) begin
        if (i_push_vld[i]) begin
          r_mem[w_wr_idx[i]] <= i_push_data[i];
        end
      end
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_arbiter
//  Purpose  : Collects completed results from the functional-unit slots into
//             an age-ordered queue and broadcasts up to N_CDB of them per
//             cycle on the common data bus, oldest on lane 0.
//  Revision : 1.0  initial release
// ============================================================================
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_SRC = ALU_RS_SIZE,
  parameter int N_CDB = NUM_CDB_ENTRIES,
  parameter int DEPTH = CDB_QUEUE_DEPTH
) (
  input  logic          clk,
  input  logic          rst,       // async, active-low
  cdb_arbiter_if.slave  bus
);

  localparam int W  = TAG_W + DATA_W;
  localparam int CW = $clog2(DEPTH+1);

  logic [N_SRC-1:0]          w_ready;
  logic [N_SRC-1:0]          w_push_vld;
  logic [N_SRC-1:0][W-1:0]   w_push_data;
  logic [CW-1:0]             w_pop_n;
  logic [CW-1:0]             w_count;
  logic [N_CDB-1:0][W-1:0]   w_rd_data;
  logic [N_CDB-1:0]          w_rd_vld;

  // Ready from registered occupancy only: lower-index sources claim free slots
  // first, and slots freed by this cycle's drain are not offered until next cycle
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      w_ready[i]     = (int'(w_count) + i + 1) <= DEPTH;
      w_push_vld[i]  = bus.src_i[i].valid & w_ready[i];
      w_push_data[i] = {bus.src_i[i].tag, bus.src_i[i].value};
    end
  end

  // The bus never stalls: every presented lane is consumed
  always_comb begin
    w_pop_n = (w_count < CW'(N_CDB)) ? w_count : CW'(N_CDB);
  end

  mp_result_queue #(
    .N_PUSH (N_SRC),
    .N_POP  (N_CDB),
    .DEPTH  (DEPTH),
    .W      (W)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (bus.flush),
    .i_push_vld  (w_push_vld),
    .i_push_data (w_push_data),
    .i_pop_n     (w_pop_n),
    .o_rd_data   (w_rd_data),
    .o_rd_vld    (w_rd_vld),
    .o_count     (w_count)
  );

  // Lane formatting: occupied lanes carry valid=1, the rest are forced to zero
  always_comb begin
    bus.cdb_o = '0;
    for (int k = 0; k < N_CDB; k++) begin
      if ((CW'(k) < w_pop_n) && w_rd_vld[k]) begin
        bus.cdb_o[k].valid = 1'b1;
        bus.cdb_o[k].tag   = w_rd_data[k][W-1:DATA_W];
        bus.cdb_o[k].value = w_rd_data[k][DATA_W-1:0];
      end
    end
  end

  assign bus.src_ready_o = w_ready;
  assign bus.count_o     = w_count;

endmodule
`default_nettype wire
